wrap_bus_fifo: RTL and testbench

Parametrised bus-side wrapper for a byte-oriented peripheral (UART transmitter or similar) on the shared system bus. It detects accesses to its address region, requests and holds bus ownership via the Breq/Bgnt handshake, and buffers each decoded write (data plus 3 command bits) in a FIFO. The peripheral drains the FIFO through a valid/ready interface, so bus writes are decoupled from peripheral throughput. It sits between the bus arbiter/bus fabric and the peripheral's load/strobe inputs.

---
 rtl/wrap_bus_fifo.sv | 211 +++++++++++++++++++++
 tb/tb_wrap_bus_fifo.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wrap_bus_fifo.sv
// wrap_bus_fifo: bus-side wrapper for a byte-oriented peripheral.
// Claims the shared bus when its address tag matches, then buffers every
// matching write ({cmd[2:0], data}) into a show-ahead FIFO.
// The peripheral drains that FIFO over a valid/ready interface.
// Optional feature macro: WRAP_TIMEOUT_EN builds the REQ timeout and Tmo_err.
module wrap_bus_fifo #(
    parameter int                DATA_W = 8,
    parameter int                ADDR_W = 32,
    parameter int                TAG_W  = 4,
    parameter logic [TAG_W-1:0]  TAG    = 4'b0010,
    parameter int                DEPTH  = 4,
    parameter int                TMO    = 15
) (
    input  logic              clk,
    input  logic              bReset,
    inout  wire  [DATA_W-1:0] DataBus,
    input  logic [ADDR_W-1:0] AddressBus,
    inout  wire               ControlBus,
    output logic              Breq,
    input  logic              Bgnt,
    output logic [DATA_W-1:0] Out_data,
    output logic [2:0]        Out_cmd,
    output logic              Out_valid,
    input  logic              Out_ready,
    output logic              Fifo_full,
    output logic              Ovf_err,
    output logic              Tmo_err,
    input  logic              Clr_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = DATA_W + 3;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_OWN} state_t;

    state_t             state_q, state_d;
    logic               match;
    logic               push_req;
    logic               tmo_hit;
    logic               pop;
    logic               do_push;
    logic               ovf_set;
    logic [PTR_W-1:0]   wr_q, wr_d, rd_q, rd_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               valid_q, full_q;
    logic [ENT_W-1:0]   head_q, head_d;
    logic [ENT_W-1:0]   entry_in;
    logic [ENT_W-1:0]   mem_q [DEPTH];
    logic               ovf_q, ovf_d;
    logic               unused_addr;

    // Only the tag field and the command bits are meaningful; the rest is ignored.
    assign unused_addr = ^AddressBus;

    assign match    = (AddressBus[ADDR_W-1 -: TAG_W] == TAG);
    assign entry_in = {AddressBus[2:0], DataBus};

    // The block never drives data; it only pulls ControlBus low while it owns the bus.
    assign ControlBus = (state_q == S_OWN) ? 1'b0 : 1'bz;
    assign Breq       = (state_q == S_REQ);

`ifdef WRAP_TIMEOUT_EN
    localparam logic [7:0] TMO_L = 8'(TMO);
    logic [7:0] wait_q, wait_d;
    logic       tmo_q, tmo_d;
`endif

    // Next state: request on tag match, own on grant, release on mismatch.
    always_comb begin
        state_d  = state_q;
        push_req = 1'b0;
        tmo_hit  = 1'b0;
`ifdef WRAP_TIMEOUT_EN
        wait_d   = wait_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (match) begin
                    state_d = S_REQ;
`ifdef WRAP_TIMEOUT_EN
                    wait_d  = 8'd0;
`endif
                end
            end
            S_REQ: begin
                if (Bgnt) begin
                    state_d = S_OWN;
                end else if (!match) begin
                    state_d = S_IDLE;
                end else begin
`ifdef WRAP_TIMEOUT_EN
                    // wait_q counts completed waiting cycles; this is the TMO-th one.
                    if (wait_q + 8'd1 == TMO_L) begin
                        state_d = S_IDLE;
                        tmo_hit = 1'b1;
                    end else begin
                        wait_d = wait_q + 8'd1;
                    end
`endif
                end
            end
            S_OWN: begin
                if (match) begin
                    push_req = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge bReset) begin
        if (!bReset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

`ifdef WRAP_TIMEOUT_EN
    // Timeout flag: a new timeout wins over a same-cycle clear.
    always_comb begin
        tmo_d = tmo_q;
        if (tmo_hit) begin
            tmo_d = 1'b1;
        end else if (Clr_err) begin
            tmo_d = 1'b0;
        end
    end

    // Wait counter and sticky timeout flag.
    always_ff @(posedge clk or negedge bReset) begin
        if (!bReset) begin
            wait_q <= 8'd0;
            tmo_q  <= 1'b0;
        end else begin
            wait_q <= wait_d;
            tmo_q  <= tmo_d;
        end
    end

    assign Tmo_err = tmo_q;
`else
    assign Tmo_err = 1'b0;
`endif

    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign pop     = valid_q && Out_ready;
    assign do_push = push_req && (!full_q || pop);
    assign ovf_set = push_req && full_q && !pop;

    // Pointer/occupancy update and show-ahead head selection.
    always_comb begin
        wr_d    = do_push ? wr_q + PTR_W'(1) : wr_q;
        rd_d    = pop ? rd_q + PTR_W'(1) : rd_q;
        count_d = count_q + CNT_W'(do_push) - CNT_W'(pop);
        head_d  = head_q;
        if (count_d != '0) begin
            // The new head is the incoming word when it lands on the new read slot.
            if (do_push && (wr_q == rd_d)) begin
                head_d = entry_in;
            end else begin
                head_d = mem_q[rd_d];
            end
        end
        ovf_d = ovf_q;
        if (ovf_set) begin
            ovf_d = 1'b1;
        end else if (Clr_err) begin
            ovf_d = 1'b0;
        end
    end

    // FIFO control registers; reset discards any buffered entries.
    always_ff @(posedge clk or negedge bReset) begin
        if (!bReset) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            valid_q <= 1'b0;
            full_q  <= 1'b0;
            head_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
            valid_q <= (count_d != '0);
            full_q  <= (count_d == CNT_W'(DEPTH));
            head_q  <= head_d;
            ovf_q   <= ovf_d;
        end
    end

    // FIFO storage array.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q] <= entry_in;
        end
    end

    assign Out_valid = valid_q;
    assign Fifo_full = full_q;
    assign Out_data  = head_q[DATA_W-1:0];
    assign Out_cmd   = head_q[ENT_W-1 -: 3];
    assign Ovf_err   = ovf_q;

endmodule

// File: tb/tb_wrap_bus_fifo.sv
// tb_wrap_bus_fifo: directed bench for wrap_bus_fifo.
// ControlBus carries a pullup (bus termination), so a released bus reads 1.
module tb_wrap_bus_fifo;

    logic        clk;
    logic        b_reset;
    logic [7:0]  data_drv;
    wire  [7:0]  data_bus;
    logic [31:0] addr_bus;
    wire         ctrl_bus;
    logic        breq;
    logic        bgnt;
    logic [7:0]  out_data;
    logic [2:0]  out_cmd;
    logic        out_valid;
    logic        out_ready;
    logic        fifo_full;
    logic        ovf_err;
    logic        tmo_err;
    logic        clr_err;

    int checks = 0;
    int errors = 0;

    assign data_bus = data_drv;
    pullup (ctrl_bus);

    wrap_bus_fifo #(
        .DATA_W(8), .ADDR_W(32), .TAG_W(4), .TAG(4'b0010), .DEPTH(4), .TMO(15)
    ) dut (
        .clk(clk),
        .bReset(b_reset),
        .DataBus(data_bus),
        .AddressBus(addr_bus),
        .ControlBus(ctrl_bus),
        .Breq(breq),
        .Bgnt(bgnt),
        .Out_data(out_data),
        .Out_cmd(out_cmd),
        .Out_valid(out_valid),
        .Out_ready(out_ready),
        .Fifo_full(fifo_full),
        .Ovf_err(ovf_err),
        .Tmo_err(tmo_err),
        .Clr_err(clr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            $display("check %s ok (%h)", tag, obs);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_bus(input logic match, input logic [2:0] cmd, input logic [7:0] dat);
        addr_bus = {(match ? 4'b0010 : 4'h0), 25'd0, cmd};
        data_drv = dat;
    endtask

    // Match with grant already high: IDLE->REQ->OWN in two edges.
    task automatic acquire(input logic [2:0] cmd, input logic [7:0] dat);
        set_bus(1'b1, cmd, dat);
        bgnt = 1'b1;
        step();
        step();
    endtask

    task automatic release_bus();
        set_bus(1'b0, 3'd0, 8'h00);
        bgnt = 1'b0;
        step();
    endtask

    initial begin
        b_reset   = 1'b0;
        data_drv  = 8'h00;
        addr_bus  = 32'd0;
        bgnt      = 1'b0;
        out_ready = 1'b0;
        clr_err   = 1'b0;
        step();
        step();
        b_reset = 1'b1;
        step();
        step();

        // Idle after reset, tag 0 on the bus.
        check_val("rst_breq",  32'(breq), 32'd0);
        check_val("rst_ctrl",  32'(ctrl_bus), 32'd1);
        check_val("rst_valid", 32'(out_valid), 32'd0);
        check_val("rst_full",  32'(fifo_full), 32'd0);
        check_val("rst_ovf",   32'(ovf_err), 32'd0);
        check_val("rst_tmo",   32'(tmo_err), 32'd0);
        check_val("rst_data",  32'(out_data), 32'd0);
        check_val("rst_cmd",   32'(out_cmd), 32'd0);

        // Request, grant after 3 cycles, two writes, then two pops.
        set_bus(1'b1, 3'b001, 8'hA5);
        step();
        check_val("req_breq", 32'(breq), 32'd1);
        check_val("req_ctrl", 32'(ctrl_bus), 32'd1);
        step();
        step();
        bgnt = 1'b1;
        step();
        check_val("own_breq",  32'(breq), 32'd0);
        check_val("own_ctrl",  32'(ctrl_bus), 32'd0);
        check_val("own_empty", 32'(out_valid), 32'd0);
        step();
        $display("write cmd=001 data=A5");
        check_val("w1_valid", 32'(out_valid), 32'd1);
        check_val("w1_data",  32'(out_data), 32'hA5);
        check_val("w1_cmd",   32'(out_cmd), 32'b001);
        set_bus(1'b1, 3'b110, 8'h3C);
        step();
        $display("write cmd=110 data=3C");
        release_bus();
        check_val("rel_ctrl", 32'(ctrl_bus), 32'd1);
        check_val("rel_head", 32'(out_data), 32'hA5);
        out_ready = 1'b1;
        step();
        $display("pop");
        check_val("p1_data",  32'(out_data), 32'h3C);
        check_val("p1_cmd",   32'(out_cmd), 32'b110);
        check_val("p1_valid", 32'(out_valid), 32'd1);
        step();
        $display("pop");
        out_ready = 1'b0;
        check_val("p2_valid", 32'(out_valid), 32'd0);
        check_val("p2_hold",  32'(out_data), 32'h3C);

        // Six writes into a 4-entry FIFO with no draining.
        acquire(3'd1, 8'h11);
        for (int i = 1; i <= 6; i++) begin
            set_bus(1'b1, 3'(i), 8'(8'h10 + i));
            step();
            $display("write cmd=%0d data=%h", i, 8'(8'h10 + i));
            if (i == 3) check_val("ovf_full3", 32'(fifo_full), 32'd0);
            if (i == 4) begin
                check_val("ovf_full4", 32'(fifo_full), 32'd1);
                check_val("ovf_err4",  32'(ovf_err), 32'd0);
            end
            if (i == 5) check_val("ovf_err5", 32'(ovf_err), 32'd1);
        end
        release_bus();
        out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            check_val($sformatf("ovf_d%0d", k), 32'(out_data), 32'(8'h10 + k));
            check_val($sformatf("ovf_c%0d", k), 32'(out_cmd), 32'(k));
            step();
            $display("pop");
        end
        out_ready = 1'b0;
        check_val("ovf_drained", 32'(out_valid), 32'd0);
        check_val("ovf_sticky",  32'(ovf_err), 32'd1);
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        check_val("ovf_clr", 32'(ovf_err), 32'd0);

        // Full FIFO with simultaneous pop and push.
        acquire(3'd5, 8'h21);
        for (int i = 1; i <= 4; i++) begin
            set_bus(1'b1, 3'd5, 8'(8'h20 + i));
            step();
            $display("write cmd=5 data=%h", 8'(8'h20 + i));
        end
        check_val("cc_full_pre", 32'(fifo_full), 32'd1);
        out_ready = 1'b1;
        set_bus(1'b1, 3'd6, 8'h25);
        step();
        $display("write cmd=6 data=25 with pop");
        out_ready = 1'b0;
        check_val("cc_full", 32'(fifo_full), 32'd1);
        check_val("cc_ovf",  32'(ovf_err), 32'd0);
        check_val("cc_head", 32'(out_data), 32'h22);
        release_bus();
        out_ready = 1'b1;
        for (int k = 2; k <= 5; k++) begin
            check_val($sformatf("cc_d%0d", k), 32'(out_data), 32'(8'h20 + k));
            check_val($sformatf("cc_c%0d", k), 32'(out_cmd), (k == 5) ? 32'd6 : 32'd5);
            step();
            $display("pop");
        end
        out_ready = 1'b0;
        check_val("cc_empty", 32'(out_valid), 32'd0);

        // Request with no grant.
        set_bus(1'b1, 3'd0, 8'h00);
        bgnt = 1'b0;
        step();
        check_val("to_breq0", 32'(breq), 32'd1);
`ifdef WRAP_TIMEOUT_EN
        for (int i = 0; i < 14; i++) step();
        check_val("to_breq14", 32'(breq), 32'd1);
        check_val("to_tmo14",  32'(tmo_err), 32'd0);
        step();
        set_bus(1'b0, 3'd0, 8'h00);
        check_val("to_breq15", 32'(breq), 32'd0);
        check_val("to_tmo15",  32'(tmo_err), 32'd1);
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        check_val("to_clr", 32'(tmo_err), 32'd0);
`else
        for (int i = 0; i < 20; i++) step();
        check_val("nt_breq", 32'(breq), 32'd1);
        check_val("nt_tmo",  32'(tmo_err), 32'd0);
        set_bus(1'b0, 3'd0, 8'h00);
        step();
        check_val("nt_drop", 32'(breq), 32'd0);
`endif

        // Asynchronous reset while owning the bus with two entries.
        acquire(3'd2, 8'h41);
        step();
        set_bus(1'b1, 3'd3, 8'h42);
        step();
        $display("write x2 then async reset");
        check_val("ar_pre_ctrl",  32'(ctrl_bus), 32'd0);
        check_val("ar_pre_valid", 32'(out_valid), 32'd1);
        #2;
        b_reset = 1'b0;
        #1;
        check_val("ar_breq",  32'(breq), 32'd0);
        check_val("ar_ctrl",  32'(ctrl_bus), 32'd1);
        check_val("ar_valid", 32'(out_valid), 32'd0);
        check_val("ar_full",  32'(fifo_full), 32'd0);
        check_val("ar_data",  32'(out_data), 32'd0);
        set_bus(1'b0, 3'd0, 8'h00);
        bgnt = 1'b0;
        b_reset = 1'b1;
        step();
        check_val("ar_post_valid", 32'(out_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
